iter_mul_unit: RTL and testbench

- Parametrised, multi-cycle successor to the datapath's single-cycle multiply path.
- Performs MUL, UMULL, SMULL, UMLAL and SMLAL on WIDTH-bit operands using a radix-2 shift-add engine.
- Uses valid/ready handshakes on both sides and produces NZ flags.
- Sits beside the ALU in the execute stage; the controller stalls on in_ready/out_valid instead of closing timing on a combinational multiplier.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_shift_add_step.sv | 16 +
 rtl/iter_mul_unit.sv | 147 ++++++++++++++
 tb/tb_iter_mul_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: op encodings, FSM states and op-class helpers for the iterative multiplier.
package mul_pkg;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_UMULL = 3'b101;
  localparam logic [2:0] OP_SMULL = 3'b111;
  localparam logic [2:0] OP_RSVD  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  function automatic logic is_long(input logic [2:0] op);
    return (op == OP_UMULL) || (op == OP_SMULL);
  endfunction

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op == OP_MUL) || is_long(op);
  endfunction
endpackage

// File: rtl/mul_shift_add_step.sv
// mul_shift_add_step: one radix-2 iteration, add multiplicand into the upper half then shift right.
module mul_shift_add_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   mplier_o
);
  logic [WIDTH:0] sum;

  assign sum      = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + {1'b0, mcand_i & {WIDTH{mplier_i[0]}}};
  assign prod_o   = {sum, prod_i[WIDTH-1:1]};
  assign mplier_o = mplier_i >> 1;
endmodule

// File: rtl/iter_mul_unit.sv
// iter_mul_unit: multi-cycle MUL/UMULL/SMULL/UMLAL/SMLAL with valid/ready handshakes and NZ flags.
module iter_mul_unit
  import mul_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [1:0]       flags_o,
  output logic             err_o
);
  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               acc_q, acc_d, neg_q, neg_d, err_pend_q, err_pend_d, err_q, err_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, lo_q, lo_d, hi_q, hi_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, accv_q, accv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         flags_q, flags_d;

  logic               accept, sgn_in;
  logic [2*WIDTH-1:0] step_prod, fixed, total;
  logic [WIDTH-1:0]   step_mplier, res_lo, res_hi;
  logic               res_n, res_z;

  mul_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .prod_i   (prod_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .prod_o   (step_prod),
    .mplier_o (step_mplier)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      op_q       <= '0;
      acc_q      <= 1'b0;
      neg_q      <= 1'b0;
      err_pend_q <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      accv_q     <= '0;
      cnt_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      err_pend_q <= err_pend_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      accv_q     <= accv_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid_i ? (is_valid_op(op_i) ? CALC : FIX) : IDLE;
      CALC:    state_d = (cnt_q == CNT_W'(1)) ? FIX : CALC;
      FIX:     state_d = DONE;
      DONE:    state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Signed operands are converted to magnitudes so the engine only ever runs unsigned.
  assign accept = (state_q == IDLE) && in_valid_i && !flush_i;
  assign sgn_in = (op_i == OP_SMULL);
  assign fixed  = neg_q ? -prod_q : prod_q;
  assign total  = fixed + ((acc_q && is_long(op_q)) ? accv_q : '0);
  assign res_lo = err_pend_q ? '0 : total[WIDTH-1:0];
  assign res_hi = (err_pend_q || !is_long(op_q)) ? '0 : total[2*WIDTH-1:WIDTH];
  assign res_z  = (res_lo == '0) && (res_hi == '0);
  assign res_n  = (op_q == OP_MUL) ? res_lo[WIDTH-1] : (op_q == OP_SMULL) ? res_hi[WIDTH-1] : 1'b0;

  always_comb begin
    op_d       = op_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    err_pend_d = err_pend_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    accv_d     = accv_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    flags_d    = flags_q;
    err_d      = err_q;
    if (accept) begin
      op_d       = op_i;
      acc_d      = acc_i;
      neg_d      = sgn_in && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      err_pend_d = !is_valid_op(op_i);
      mcand_d    = (sgn_in && a_i[WIDTH-1]) ? -a_i : a_i;
      mplier_d   = (sgn_in && b_i[WIDTH-1]) ? -b_i : b_i;
      prod_d     = '0;
      accv_d     = {acc_hi_i, acc_lo_i};
      cnt_d      = is_valid_op(op_i) ? CNT_W'(WIDTH) : '0;
    end else if (state_q == CALC) begin
      prod_d     = step_prod;
      mplier_d   = step_mplier;
      cnt_d      = cnt_q - CNT_W'(1);
    end else if (state_q == FIX && !flush_i) begin
      lo_d       = res_lo;
      hi_d       = res_hi;
      flags_d    = err_pend_q ? 2'b00 : {res_n, res_z};
      err_d      = err_pend_q;
    end
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    result_lo_o = lo_q;
    result_hi_o = hi_q;
    flags_o     = flags_q;
    err_o       = err_q;
  end
endmodule

// File: tb/tb_iter_mul_unit.sv
// tb_iter_mul_unit: scoreboard bench for 32-bit and 8-bit instances of iter_mul_unit.
module tb_iter_mul_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid32 = 0, acc32 = 0, out_ready32 = 0;
  logic [2:0]  op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, alo32 = 0, ahi32 = 0;
  logic        in_ready32, out_valid32, err32;
  logic [31:0] lo32, hi32;
  logic [1:0]  fl32;

  logic        in_valid8 = 0, acc8 = 0, out_ready8 = 0;
  logic [2:0]  op8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, alo8 = 0, ahi8 = 0;
  logic        in_ready8, out_valid8, err8;
  logic [7:0]  lo8, hi8;
  logic [1:0]  fl8;

  iter_mul_unit #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid32), .in_ready_o(in_ready32),
    .op_i(op32), .acc_i(acc32), .a_i(a32), .b_i(b32), .acc_lo_i(alo32), .acc_hi_i(ahi32),
    .out_valid_o(out_valid32), .out_ready_i(out_ready32), .result_lo_o(lo32), .result_hi_o(hi32),
    .flags_o(fl32), .err_o(err32));

  iter_mul_unit #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(1'b0), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .op_i(op8), .acc_i(acc8), .a_i(a8), .b_i(b8), .acc_lo_i(alo8), .acc_hi_i(ahi8),
    .out_valid_o(out_valid8), .out_ready_i(out_ready8), .result_lo_o(lo8), .result_hi_o(hi8),
    .flags_o(fl8), .err_o(err8));

  typedef struct {
    logic        err;
    logic [1:0]  fl;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference: full-width arithmetic mod 2^64, then reduced to the instance width.
  function automatic exp_t model(input int w, input logic [2:0] op, input logic acc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] alo, input logic [31:0] ahi, input string name);
    logic [63:0] mw, m2w, ua, ub, sa, sbv, p, t;
    exp_t e;
    mw  = (64'd1 << w) - 64'd1;
    m2w = (64'd1 << (2 * w)) - 64'd1;
    ua  = {32'b0, a} & mw;
    ub  = {32'b0, b} & mw;
    sa  = ua[w-1] ? (ua | ~mw) : ua;
    sbv = ub[w-1] ? (ub | ~mw) : ub;
    e.name = name;
    e.err  = !(op == 3'b100 || op == 3'b101 || op == 3'b111);
    e.lat  = e.err ? 2 : w + 2;
    e.lo = 0; e.hi = 0; e.fl = 0;
    if (e.err) return e;
    if (op == 3'b100) begin
      t = (ua * ub) & mw;
      e.lo = t[31:0];
      e.fl = {t[w-1], t == 64'd0};
    end else begin
      p = (op == 3'b111) ? sa * sbv : ua * ub;
      if (acc) p = p + ((({32'b0, ahi} & mw) << w) | ({32'b0, alo} & mw));
      p = p & m2w;
      t = p & mw;
      e.lo = t[31:0];
      t = (p >> w) & mw;
      e.hi = t[31:0];
      e.fl = {(op == 3'b111) ? t[w-1] : 1'b0, p == 64'd0};
    end
    return e;
  endfunction

  task automatic drive(input bit w8, input logic [2:0] op, input logic acc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] alo, input logic [31:0] ahi, input logic v);
    if (w8) begin
      in_valid8 = v; op8 = op; acc8 = acc; a8 = a[7:0]; b8 = b[7:0]; alo8 = alo[7:0]; ahi8 = ahi[7:0];
    end else begin
      in_valid32 = v; op32 = op; acc32 = acc; a32 = a; b32 = b; alo32 = alo; ahi32 = ahi;
    end
  endtask

  task automatic sample(input bit w8, output logic ov, output logic ir, output logic er,
                        output logic [31:0] lo, output logic [31:0] hi, output logic [1:0] fl);
    if (w8) begin
      ov = out_valid8; ir = in_ready8; er = err8; lo = {24'b0, lo8}; hi = {24'b0, hi8}; fl = fl8;
    end else begin
      ov = out_valid32; ir = in_ready32; er = err32; lo = lo32; hi = hi32; fl = fl32;
    end
  endtask

  // Waits for in_ready, pushes the expectation, presents one beat, then scrambles the inputs.
  task automatic issue(input bit w8, input logic [2:0] op, input logic acc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] alo, input logic [31:0] ahi, input string name);
    logic ov, ir, er; logic [31:0] lo, hi; logic [1:0] fl; int n;
    n = 0;
    @(negedge clk);
    sample(w8, ov, ir, er, lo, hi, fl);
    while (!ir && n < 100) begin
      @(negedge clk); n++;
      sample(w8, ov, ir, er, lo, hi, fl);
    end
    checks++;
    if (!ir) begin
      errors++;
      $display("FAIL %s accept: in_ready=%0b required 1 within 100 cycles", name, ir);
    end
    sb.push_back(model(w8 ? 8 : 32, op, acc, a, b, alo, ahi, name));
    drive(w8, op, acc, a, b, alo, ahi, 1'b1);
    @(posedge clk); #1;
    drive(w8, 3'b110, ~acc, ~a, $urandom, $urandom, $urandom, 1'b0);
  endtask

  task automatic check_result(input bit w8);
    logic ov, ir, er; logic [31:0] lo, hi; logic [1:0] fl; int n; exp_t e;
    n = 0;
    do begin
      @(negedge clk); n++;
      sample(w8, ov, ir, er, lo, hi, fl);
    end while (!ov && n < 100);
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard: result with no pending expectation");
      return;
    end
    e = sb.pop_front();
    if (!ov) begin
      errors++; $display("FAIL %s out_valid: got 0 required 1 within 100 cycles", e.name);
      return;
    end
    checks++; if (n !== e.lat) begin errors++; $display("FAIL %s latency: got %0d required %0d", e.name, n, e.lat); end
    checks++; if (lo !== e.lo) begin errors++; $display("FAIL %s lo: got %h required %h", e.name, lo, e.lo); end
    checks++; if (hi !== e.hi) begin errors++; $display("FAIL %s hi: got %h required %h", e.name, hi, e.hi); end
    checks++; if (fl !== e.fl) begin errors++; $display("FAIL %s flags: got %b required %b", e.name, fl, e.fl); end
    checks++; if (er !== e.err) begin errors++; $display("FAIL %s err: got %b required %b", e.name, er, e.err); end
    checks++; if (ir !== 1'b0) begin errors++; $display("FAIL %s in_ready in DONE: got %b required 0", e.name, ir); end
  endtask

  task automatic retire(input bit w8, input string name);
    logic ov, ir, er; logic [31:0] lo, hi; logic [1:0] fl;
    if (w8) out_ready8 = 1'b1; else out_ready32 = 1'b1;
    @(negedge clk);
    if (w8) out_ready8 = 1'b0; else out_ready32 = 1'b0;
    sample(w8, ov, ir, er, lo, hi, fl);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL %s retire out_valid: got %b required 0", name, ov); end
    checks++; if (ir !== 1'b1) begin errors++; $display("FAIL %s retire in_ready: got %b required 1", name, ir); end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({in_ready32, out_valid32, lo32, hi32, fl32, err32} !== {1'b1, 1'b0, 64'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL %s: rdy=%b vld=%b lo=%h hi=%h fl=%b err=%b required 1 0 0 0 00 0",
               name, in_ready32, out_valid32, lo32, hi32, fl32, err32);
    end
    checks++;
    if ({in_ready8, out_valid8, lo8, hi8, fl8, err8} !== {1'b1, 1'b0, 16'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL %s w8: rdy=%b vld=%b lo=%h hi=%h fl=%b err=%b required 1 0 0 0 00 0",
               name, in_ready8, out_valid8, lo8, hi8, fl8, err8);
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    issue(0, 3'b100, 0, 32'd7, 32'd6, 0, 0, "mul_7x6"); check_result(0); retire(0, "mul_7x6");
    issue(0, 3'b100, 1, 32'hFFFFFFFF, 32'd2, 32'h5, 32'h9, "mul_neg_acc_ignored"); check_result(0); retire(0, "mul_neg");
    issue(0, 3'b100, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, "mul_max"); check_result(0); retire(0, "mul_max");
  endtask

  task automatic test_long();
    issue(0, 3'b111, 0, 32'hFFFFFFFF, 32'd2, 0, 0, "smull_m1x2"); check_result(0); retire(0, "smull_m1x2");
    issue(0, 3'b101, 0, 32'hFFFFFFFF, 32'd2, 0, 0, "umull_ffx2"); check_result(0); retire(0, "umull_ffx2");
    issue(0, 3'b111, 0, 32'h80000000, 32'h80000000, 0, 0, "smull_min_min"); check_result(0); retire(0, "smull_min");
    issue(0, 3'b101, 0, 32'd0, 32'd5, 0, 0, "umull_zero"); check_result(0); retire(0, "umull_zero");
    issue(0, 3'b111, 0, 32'h80000000, 32'h7FFFFFFF, 0, 0, "smull_min_max"); check_result(0); retire(0, "smull_mm");
  endtask

  task automatic test_accumulate();
    issue(0, 3'b101, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, "umlal_max"); check_result(0); retire(0, "umlal");
    issue(0, 3'b111, 1, 32'hFFFFFFFD, 32'd4, 32'd12, 32'd0, "smlal_zero"); check_result(0); retire(0, "smlal");
    issue(0, 3'b111, 1, 32'h12345, 32'hFFFF0001, 32'hDEADBEEF, 32'h80000000, "smlal_wrap"); check_result(0); retire(0, "smlal_w");
  endtask

  task automatic test_hold();
    exp_t h;
    h = model(32, 3'b101, 0, 32'h12345678, 32'h9ABCDEF0, 0, 0, "hold");
    issue(0, 3'b101, 0, 32'h12345678, 32'h9ABCDEF0, 0, 0, "hold");
    check_result(0);
    out_ready8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid32, in_ready32, lo32, hi32, fl32} !== {1'b1, 1'b0, h.lo, h.hi, h.fl}) begin
        errors++;
        $display("FAIL hold cycle %0d: vld=%b rdy=%b lo=%h hi=%h fl=%b required 1 0 %h %h %b",
                 i, out_valid32, in_ready32, lo32, hi32, fl32, h.lo, h.hi, h.fl);
      end
    end
    out_ready8 = 1'b0;
    retire(0, "hold");
  endtask

  task automatic test_flush();
    int seen;
    issue(0, 3'b100, 0, 32'd7, 32'd6, 0, 0, "pre_flush"); check_result(0); retire(0, "pre_flush");
    issue(0, 3'b101, 0, 32'hCAFEF00D, 32'h0BADBEEF, 0, 0, "flushed");
    void'(sb.pop_back());
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL flush in_ready: got %b required 1", in_ready32); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid32) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush out_valid: high %0d cycles required 0", seen); end
    checks++; if (lo32 !== 32'd42) begin errors++; $display("FAIL flush keeps lo: got %h required 0000002a", lo32); end
    flush = 1'b1;
    drive(0, 3'b010, 0, 32'd1, 32'd1, 0, 0, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    drive(0, 3'b100, 0, 0, 0, 0, 0, 1'b0);
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL flush_vs_accept in_ready: got %b required 1", in_ready32); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid32) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_vs_accept out_valid: high %0d cycles required 0", seen); end
  endtask

  task automatic test_async_reset();
    issue(0, 3'b111, 0, 32'h7, 32'h9, 0, 0, "async_rst");
    void'(sb.pop_back());
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset_mid_calc");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_w8();
    issue(1, 3'b111, 0, 32'h81, 32'h7F, 0, 0, "w8_smull"); check_result(1); retire(1, "w8_smull");
    issue(1, 3'b010, 0, 32'h12, 32'h34, 0, 0, "w8_reserved"); check_result(1); retire(1, "w8_rsvd");
    issue(1, 3'b101, 1, 32'hFF, 32'hFF, 32'h02, 32'h01, "w8_umlal"); check_result(1); retire(1, "w8_umlal");
    issue(1, 3'b110, 0, 32'h3, 32'h3, 0, 0, "w8_op110"); check_result(1); retire(1, "w8_op110");
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [3];
    ops[0] = 3'b100; ops[1] = 3'b101; ops[2] = 3'b111;
    for (int i = 0; i < 10; i++) begin
      issue(0, ops[$urandom_range(0, 2)], 1'($urandom), $urandom, $urandom, $urandom, $urandom, $sformatf("b2b_%0d", i));
      check_result(0);
      retire(0, "b2b");
    end
    issue(0, 3'b000, 0, 32'd3, 32'd3, 0, 0, "w32_reserved"); check_result(0); retire(0, "w32_rsvd");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_long();
    test_accumulate();
    test_hold();
    test_flush();
    test_async_reset();
    test_w8();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
